// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vend_pkg
//  Brief    : Shared vending-machine constants, FSM state encoding and helpers.
//  Revision : 1.0
// ============================================================================
package vend_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_IDLE       = 2'd0;
    localparam state_t c_PRESS_FILT = 2'd1;
    localparam state_t c_DOWN       = 2'd2;
    localparam state_t c_REL_FILT   = 2'd3;

    localparam int c_SYS_CLK_HZ      = 50_000_000;
    // 20 ms worth of system-clock cycles
    localparam int c_CNT_MAX_DEFAULT = c_SYS_CLK_HZ / 50;

    // True while the filtered sensor level counts as "coin present"
    function automatic logic is_held(input state_t s);
        return (s == c_DOWN) || (s == c_REL_FILT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Brief    : Generic two-flop synchroniser with a configurable reset level.
//  Revision : 1.0
// ============================================================================
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Only the second stage is visible; the first may be metastable
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/coin_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : coin_debounce
//  Brief    : Synchronises and debounces the coin sensor, emitting one pulse
//             per inserted coin. Optional macro COIN_CNT_EN adds a coin count.
//  Revision : 1.0
// ============================================================================
module coin_debounce
    import vend_pkg::*;
#(
    parameter int CNT_MAX    = c_CNT_MAX_DEFAULT,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_in,
    output logic       po_money,
    output logic       o_stable
`ifdef COIN_CNT_EN
    ,
    output logic [7:0] o_coin_cnt
`endif
);

    localparam int                 CNT_W      = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0]   c_CNT_LAST = CNT_W'(CNT_MAX - 1);
    localparam logic [CNT_W-1:0]   c_CNT_ONE  = CNT_W'(1);

    logic             key_sync;
    logic             act;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             po_money_q;
    logic             po_money_d;
    logic             stable_q;
    logic             stable_d;

    sync_2ff #(
        .RST_VAL (ACTIVE_LOW)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (key_in),
        .q_o (key_sync)
    );

    assign act = key_sync ^ ACTIVE_LOW;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= c_IDLE;
            cnt_q      <= '0;
            po_money_q <= 1'b0;
            stable_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            po_money_q <= po_money_d;
            stable_q   <= stable_d;
        end
    end

    // The counter is cleared on every state exit, so it can never wrap
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            c_IDLE: begin
                cnt_d = '0;
                if (act) begin
                    state_d = c_PRESS_FILT;
                end
            end
            c_PRESS_FILT: begin
                if (!act) begin
                    state_d = c_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == c_CNT_LAST) begin
                    state_d = c_DOWN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
            c_DOWN: begin
                cnt_d = '0;
                if (!act) begin
                    state_d = c_REL_FILT;
                end
            end
            c_REL_FILT: begin
                if (act) begin
                    state_d = c_DOWN;
                    cnt_d   = '0;
                end else if (cnt_q == c_CNT_LAST) begin
                    state_d = c_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
            default: begin
                state_d = c_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Only a filtered press may pulse; a release glitch re-entering DOWN may not
    always_comb begin
        po_money_d = (state_q == c_PRESS_FILT) && (state_d == c_DOWN);
        stable_d   = is_held(state_d);
    end

    assign po_money = po_money_q;
    assign o_stable = stable_q;

`ifdef COIN_CNT_EN
    logic [7:0] coin_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            coin_cnt_q <= 8'd0;
        end else if (po_money_d) begin
            coin_cnt_q <= coin_cnt_q + 8'd1;
        end
    end

    assign o_coin_cnt = coin_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_coin_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : tb_coin_debounce
//  Brief    : Self-checking bench for coin_debounce (CNT_MAX=8, active-low).
//  Revision : 1.0
// ============================================================================
module tb_coin_debounce;

    localparam int CNT_MAX = 8;
    localparam int LAT     = CNT_MAX + 3;

    logic       clk;
    logic       rst;
    logic       key_in;
    logic       po_money;
    logic       o_stable;
`ifdef COIN_CNT_EN
    logic [7:0] o_coin_cnt;
`endif

    coin_debounce #(
        .CNT_MAX    (CNT_MAX),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .po_money   (po_money),
        .o_stable   (o_stable)
`ifdef COIN_CNT_EN
        ,
        .o_coin_cnt (o_coin_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: the filtered level flips once CNT_MAX+1 consecutive
    // synchronised samples disagree with it; a rising flip is a coin.
    int         cyc = 0;
    logic       m_s1, m_s2;
    bit         m_act, m_level, m_pulse, m_valid;
    int         m_run;
    int         m_pulses = 0;
    logic [7:0] m_coins;

    int dut_pulses = 0, last_pulse_cyc = -1;
    int falls = 0, rises = 0, last_fall_cyc = -1;
    bit prev_stable = 1'b0;

    initial begin
        m_valid = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_s1 = 1'b1; m_s2 = 1'b1;
                m_level = 1'b0; m_run = 0; m_pulse = 1'b0;
                m_coins = 8'd0; m_valid = 1'b1;
            end else if (m_valid) begin
                m_act = (m_s2 == 1'b0);
                m_s2  = m_s1;
                m_s1  = key_in;
                m_pulse = 1'b0;
                if (m_act != m_level) begin
                    m_run++;
                    if (m_run == CNT_MAX + 1) begin
                        m_level = !m_level;
                        m_run   = 0;
                        m_pulse = m_level;
                    end
                end else begin
                    m_run = 0;
                end
                if (m_pulse) begin
                    m_coins = m_coins + 8'd1;
                    m_pulses++;
                end
            end
            #1;
            if (m_valid) begin
                cmp("po_money", {7'd0, po_money}, {7'd0, m_pulse});
                cmp("o_stable", {7'd0, o_stable}, {7'd0, m_level});
`ifdef COIN_CNT_EN
                cmp("o_coin_cnt", o_coin_cnt, m_coins);
`endif
                if (po_money === 1'b1) begin
                    dut_pulses++;
                    last_pulse_cyc = cyc;
                end
                if (prev_stable && o_stable === 1'b0) begin
                    falls++;
                    last_fall_cyc = cyc;
                end
                if (!prev_stable && o_stable === 1'b1) rises++;
                prev_stable = (o_stable === 1'b1);
            end
        end
    end

    // Drive key_in=v for n cycles; t returns the cycle index of the first drive
    task automatic seg(input logic v, input int n, output int t);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            key_in = v;
            if (i == 0) t = cyc;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, tr, tx, p0, mp0, f0, r0;
        rst    = 1'b1;
        key_in = 1'b1;
        repeat (3) @(negedge clk);
        cmp("reset_po_money", {7'd0, po_money}, 8'd0);
        cmp("reset_o_stable", {7'd0, o_stable}, 8'd0);
`ifdef COIN_CNT_EN
        cmp("reset_coin_cnt", o_coin_cnt, 8'd0);
`endif
        rst = 1'b0;
        seg(1'b1, 20, tx);

        // Clean press and release
        p0 = dut_pulses; mp0 = m_pulses;
        seg(1'b0, 40, t0);
        seg(1'b1, 30, t1);
        chk("clean_pulses", dut_pulses - p0, 1);
        chk("clean_model_pulses", m_pulses - mp0, 1);
        chk("clean_pulse_latency", last_pulse_cyc - t0, LAT);
        chk("clean_release_latency", last_fall_cyc - t1, LAT);

        // Bouncing press
        p0 = dut_pulses; mp0 = m_pulses;
        for (int i = 0; i < 5; i++) begin
            seg(1'b0, 3, tx);
            seg(1'b1, 3, tx);
        end
        seg(1'b0, 30, t0);
        seg(1'b1, 30, t1);
        chk("bounce_pulses", dut_pulses - p0, 1);
        chk("bounce_model_pulses", m_pulses - mp0, 1);
        chk("bounce_pulse_latency", last_pulse_cyc - t0, LAT);

        // Release glitch while held
        p0 = dut_pulses; f0 = falls;
        seg(1'b0, 20, tx);
        seg(1'b1, 5, tx);
        seg(1'b0, 10, tx);
        seg(1'b1, 30, t1);
        chk("relglitch_pulses", dut_pulses - p0, 1);
        chk("relglitch_falls", falls - f0, 1);
        chk("relglitch_release_latency", last_fall_cyc - t1, LAT);

        // Short press glitch
        p0 = dut_pulses; r0 = rises;
        seg(1'b0, 6, tx);
        seg(1'b1, 30, tx);
        chk("glitch_pulses", dut_pulses - p0, 0);
        chk("glitch_rises", rises - r0, 0);

        // Reset in the middle of the press filter, sensor kept active
        p0 = dut_pulses;
        seg(1'b0, 8, t0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        @(negedge clk); rst = 1'b0; tr = cyc;
        chk("midreset_no_pulse", dut_pulses - p0, 0);
        seg(1'b0, 20, tx);
        seg(1'b1, 30, t1);
        chk("midreset_pulses", dut_pulses - p0, 1);
        chk("midreset_pulse_latency", last_pulse_cyc - tr, LAT);

`ifdef COIN_CNT_EN
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        p0 = dut_pulses;
        for (int i = 0; i < 257; i++) begin
            seg(1'b0, 12, tx);
            seg(1'b1, 12, tx);
        end
        chk("coin_presses", dut_pulses - p0, 257);
        chk("coin_model_cnt", int'(m_coins), 1);
        cmp("coin_cnt_wrap", o_coin_cnt, 8'd1);
`endif

        // Random segments with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                @(negedge clk); rst = 1'b1;
                repeat ($urandom_range(0, 1)) @(negedge clk);
                @(negedge clk); rst = 1'b0;
            end
            seg(1'($urandom_range(0, 1)), $urandom_range(1, 2 * CNT_MAX + 4), tx);
        end
        seg(1'b1, 30, tx);
        chk("random_total_pulses", dut_pulses, m_pulses);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
